tmds_serializer: RTL
====================

// Module: tmds_serializer
// PURPOSE
//  Parametrised TMDS output stage in the serial-clock domain: buffers pre-encoded 10-bit
//  symbols for N data lanes in a small FIFO and shifts them out 1, 2 or 5 bits per clock.
//  Also generates the TMDS clock lane and complementary (_n) outputs.
//  Sits between the tmds_encoder instances and the SDR/DDR/gearbox output primitives.
//  If a symbol slot arrives with no queued word, it sends a safe control symbol and flags
//  an underflow.
// PARAMETERS
//  CHANNELS      3              number of data lanes (1..4)
//  BITS_PER_CLK  1              bits emitted per lane per clk; legal values 1, 2, 5
//  FIFO_DEPTH    4              symbol-word FIFO depth; power of two, >=2
//  IDLE_SYMBOL   10'b1101010100 word sent on every lane when the FIFO is empty
//  DIFF_OUT      1              1: drive *_n outputs; 0: *_n held at 0
// PORTS
//  clk            in   1             serial clock (10/BITS_PER_CLK x pixel rate)
//  reset          in   1             asynchronous, active-high reset
//  in_data        in   10*CHANNELS   symbol word; lane c at [10c+9:10c], bit 0 sent first
//  in_valid       in   1             word offered this cycle
//  in_ready       out  1             FIFO not full; push occurs when in_valid && in_ready
//  fill           out  clog2(D)+1    words currently queued (0..FIFO_DEPTH)
//  load           out  1             one-cycle pulse: shift registers loaded this cycle
//  underflow      out  1             sticky: a slot was filled with IDLE_SYMBOL
//  underflow_clr  in   1             clears underflow
//  out_tmds       out  B*CHANNELS    lane c at [Bc+B-1:Bc], B=BITS_PER_CLK; bit 0 is earliest
//  out_tmds_n     out  B*CHANNELS    bitwise complement of out_tmds, same cycle
//  out_tmds_clk   out  B             clock lane, pattern 10'b0000011111
//  out_tmds_clk_n out  B             complement of out_tmds_clk
// BEHAVIOUR
//  - W = 10/BITS_PER_CLK clocks per word.
//  - Phase counter 0..W-1 increments every clk and wraps W-1 -> 0.
//  - Load cycle is phase==W-1.
//    - FIFO non-empty: pop the head into the lane shift registers.
//    - FIFO empty: load IDLE_SYMBOL on all lanes and set underflow.
//    - Clock-lane register loads 10'b0000011111.
//    - load=1 in this cycle.
//  - Other cycles: every shift register shifts right by B bits, zero-filled.
//  - Outputs are registered copies of shreg[B-1:0].
//    - A loaded word's bits 0..B-1 appear the cycle after the load.
//    - Bits 10-B..9 appear W cycles after the load.
//  - _n outputs come from separate registers loaded from complemented data in the same cycle.
//    They have zero skew versus the true outputs.
//  - FIFO: first-in first-out, order preserved, no fall-through.
//    - A word pushed in the load cycle itself is not sent in that slot.
//      If the FIFO was empty, IDLE_SYMBOL goes instead.
//  - in_ready = (fill != FIFO_DEPTH), combinational from fill.
//    - When full, a push is refused even if a pop happens in the same cycle.
//  - Simultaneous push and pop (not full): fill unchanged; both take effect.
//  - Pointers wrap modulo FIFO_DEPTH; fill is an explicit counter (never inferred).
//  - underflow: set has priority over underflow_clr in the same cycle.
//  - Reset (async, any time, including mid-word):
//    - phase=0, FIFO empty, fill=0, load=0, underflow=0.
//    - All shift registers and all out_* / out_*_n = 0.
//    - in_ready=1.
//  - After reset release, the first load happens at cycle W-1.
//    Outputs stay 0 until the cycle after it.
// TESTING
//  1 B=1,CH=3: push 10'h3FF,10'h000,10'h2AA on lane0 before first load ->
//    lane0 emits 1 x10, then 0 x10, then 0,1,0,1,0,1,0,1,0,1.
//    clk lane emits 1,1,1,1,1,0,0,0,0,0 repeating; every _n output is the exact complement.
//  2 No pushes after reset -> every lane emits 0,0,1,0,1,0,1,0,1,1 per word.
//    underflow=1 after the first load; pulsing underflow_clr while the FIFO is fed keeps it at 0.
//  3 FIFO_DEPTH=4: hold in_valid for 6 words from reset ->
//    fill reaches 4 and in_ready=0 until the next load pops one.
//    All 6 words are emitted in order with no loss or duplication.
//  4 B=2: word 10'b1100100111 -> lane emits 2'b11,2'b01,2'b10,2'b00,2'b11; load every 5 clks.
//    B=5: same word -> 5'b00111 then 5'b11001.
//  5 Assert reset mid-word with fill=3 -> outputs, fill and underflow are 0 immediately.
//    After release, load first pulses at cycle W-1 and sends IDLE_SYMBOL.
//  6 underflow_clr=1 in the same cycle as an empty-FIFO load -> underflow reads 1 next cycle.

Source files
------------

// File: rtl/tmds_serializer.sv
// TMDS output stage in the serial-clock domain.
// Queues pre-encoded 10-bit symbol words for CHANNELS lanes in a small FIFO.
// Shifts each word out BITS_PER_CLK bits per clock, LSB first.
// Also drives the TMDS clock lane and the complementary outputs.
// An empty FIFO at a word slot sends IDLE_SYMBOL and raises a sticky underflow flag.
module tmds_serializer #(
  parameter int         CHANNELS     = 3,
  parameter int         BITS_PER_CLK = 1,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [9:0] IDLE_SYMBOL  = 10'b1101010100,
  parameter bit         DIFF_OUT     = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [10*CHANNELS-1:0]           in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [$clog2(FIFO_DEPTH):0]      fill,
  output logic                             load,
  output logic                             underflow,
  input  logic                             underflow_clr,
  output logic [BITS_PER_CLK*CHANNELS-1:0] out_tmds,
  output logic [BITS_PER_CLK*CHANNELS-1:0] out_tmds_n,
  output logic [BITS_PER_CLK-1:0]          out_tmds_clk,
  output logic [BITS_PER_CLK-1:0]          out_tmds_clk_n
);

  localparam int B  = BITS_PER_CLK;
  localparam int W  = 10 / B;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(W);

  localparam logic [PW-1:0] LAST_PHASE  = PW'(W - 1);
  localparam logic [AW:0]   FILL_FULL   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [9:0]    CLK_PATTERN = 10'b0000011111;

  // Slot timing
  logic [PW-1:0] phase_q, phase_d;
  logic          load_slot;

  // Symbol-word FIFO
  logic [10*CHANNELS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            fill_q;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  // Sticky underflow flag
  logic underflow_q;

  // Lane and clock-lane shift registers plus registered serial outputs
  logic [10*CHANNELS-1:0] shreg_q, shreg_d;
  logic [9:0]             clk_shreg_q, clk_shreg_d;
  logic [B*CHANNELS-1:0]  out_q, out_n_q, out_d;
  logic [B-1:0]           clk_out_q, clk_out_n_q, clk_out_d;

  // Slot control: load on the last phase, pop only when a word is waiting.
  always_comb begin
    load_slot  = (phase_q == LAST_PHASE);
    phase_d    = load_slot ? '0 : phase_q + 1'b1;
    fifo_empty = (fill_q == '0);
    in_ready   = (fill_q != FILL_FULL);
    push       = in_valid && in_ready;
    pop        = load_slot && !fifo_empty;
  end

  // Next shift-register contents: load a fresh word on the slot, otherwise shift right zero-filled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    shreg_d     = shreg_q;
    clk_shreg_d = clk_shreg_q;
    out_d       = '0;
    clk_out_d   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (load_slot) begin
        shreg_d[10*c +: 10] = fifo_empty ? IDLE_SYMBOL : mem_q[rd_ptr_q][10*c +: 10];
      end else begin
        shreg_d[10*c +: 10] = shreg_q[10*c +: 10] >> B;
      end
      out_d[B*c +: B] = shreg_d[10*c +: B];
    end
    clk_shreg_d = load_slot ? CLK_PATTERN : (clk_shreg_q >> B);
    clk_out_d   = clk_shreg_d[B-1:0];
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; emptiness is carried by the pointers and fill counter alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Phase counter, FIFO pointers, explicit fill counter and sticky underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state is only ever updated with non-blocking assignments.
      phase_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      // Setting wins over clearing when both happen in one cycle.
      if (load_slot && fifo_empty) begin
        underflow_q <= 1'b1;
      end else if (underflow_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Shift registers and output registers; true and complement outputs load on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q     <= '0;
      clk_shreg_q <= '0;
      out_q       <= '0;
      out_n_q     <= '0;
      clk_out_q   <= '0;
      clk_out_n_q <= '0;
    end else begin
      shreg_q     <= shreg_d;
      clk_shreg_q <= clk_shreg_d;
      out_q       <= out_d;
      out_n_q     <= DIFF_OUT ? ~out_d : '0;
      clk_out_q   <= clk_out_d;
      clk_out_n_q <= DIFF_OUT ? ~clk_out_d : '0;
    end
  end

  assign fill           = fill_q;
  assign load           = load_slot;
  assign underflow      = underflow_q;
  assign out_tmds       = out_q;
  assign out_tmds_n     = out_n_q;
  assign out_tmds_clk   = clk_out_q;
  assign out_tmds_clk_n = clk_out_n_q;

endmodule
